// File: rtl/mem_boot_loader_if.sv
// Signal bundle for mem_boot_loader: image stream in, memory write port, CPU reset and status out.
// master = the loader, slave = the image source / memories / core side.
interface mem_boot_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int NCH    = 2
);
  logic                      start;
  logic [NCH*ADDR_W-1:0]     ch_base;
  logic [NCH*(ADDR_W+1)-1:0] ch_len;
  // Stream handshake: a word moves on every clk edge where s_valid && s_ready are both high;
  // s_data is only meaningful with s_valid, and the source holds it until it is accepted.
  logic                      s_valid;
  logic [DATA_W-1:0]         s_data;
  logic                      s_ready;
  logic [NCH-1:0]            mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      cpu_rst;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    input  start, ch_base, ch_len, s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    output start, ch_base, ch_len, s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/mem_boot_loader.sv
// Streams a boot image into NCH memory channels, holding the CPU in reset until done + RST_HOLD.
// Optional per-channel checksum word checking is enabled by defining BOOT_CHECKSUM_EN.
module mem_boot_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int NCH      = 2,
  parameter int RST_HOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_boot_loader_if.master        bus,
  output logic [2:0]               fsm_state
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3
`ifdef BOOT_CHECKSUM_EN
    , S_ERR = 3'd4
`endif
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_q [NCH];
  logic [ADDR_W:0]   len_q  [NCH];
  logic [CW-1:0]     ch;
  logic [ADDR_W:0]   cnt, cnt_inc;
  logic [HW-1:0]     hold_cnt;
  logic [NCH-1:0]    we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              launch, xfer, last_word, advance, is_data;
  logic              first_found, nxt_found;
  logic [CW-1:0]     first_ch, nxt_ch;
`ifdef BOOT_CHECKSUM_EN
  logic              chk_phase;
  logic [DATA_W-1:0] sum;
`endif

  // Lowest nonzero channel of the incoming lengths, and next nonzero channel above the pointer.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.ch_len[i*(ADDR_W+1) +: ADDR_W+1] != '0) begin
        first_found = 1'b1;
        first_ch    = CW'(i);
      end
      if (i > int'(ch) && len_q[i] != '0) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(i);
      end
    end
  end

  assign xfer      = bus.s_valid && (state == S_LOAD);
  assign cnt_inc   = cnt + CNT_ONE;
  assign last_word = (cnt_inc == len_q[ch]);

`ifdef BOOT_CHECKSUM_EN
  assign launch  = bus.start && (state == S_IDLE || state == S_RUN || state == S_ERR);
  assign is_data = !chk_phase;
  assign advance = xfer && chk_phase && (bus.s_data == sum);
`else
  assign launch  = bus.start && (state == S_IDLE || state == S_RUN);
  assign is_data = 1'b1;
  assign advance = xfer && last_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.s_ready = 1'b0;
    bus.cpu_rst = 1'b1;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.err     = 1'b0;
    case (state)
      S_IDLE: if (launch) state_next = first_found ? S_LOAD : S_HOLD;
      S_LOAD: begin
        bus.s_ready = 1'b1;
        bus.busy    = 1'b1;
        if (advance && !nxt_found) state_next = S_HOLD;
`ifdef BOOT_CHECKSUM_EN
        if (xfer && chk_phase && bus.s_data != sum) state_next = S_ERR;
`endif
      end
      S_HOLD: begin
        bus.busy = 1'b1;
        if (hold_cnt == HW'(RST_HOLD - 1)) state_next = S_RUN;
      end
      S_RUN: begin
        bus.cpu_rst = 1'b0;
        bus.done    = 1'b1;
        if (launch) state_next = first_found ? S_LOAD : S_HOLD;
      end
`ifdef BOOT_CHECKSUM_EN
      S_ERR: begin
        bus.err = 1'b1;
        if (launch) state_next = first_found ? S_LOAD : S_HOLD;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch       <= '0;
      cnt      <= '0;
      hold_cnt <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
`ifdef BOOT_CHECKSUM_EN
      chk_phase <= 1'b0;
      sum       <= '0;
`endif
    end else begin
      we_q     <= '0;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + HW'(1) : '0;
      if (launch) begin
        for (int i = 0; i < NCH; i++) begin
          base_q[i] <= bus.ch_base[i*ADDR_W +: ADDR_W];
          len_q[i]  <= bus.ch_len[i*(ADDR_W+1) +: ADDR_W+1];
        end
        ch  <= first_ch;
        cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
        chk_phase <= 1'b0;
        sum       <= '0;
`endif
      end
      if (xfer && is_data) begin
        we_q    <= NCH'(1) << ch;
        addr_q  <= base_q[ch] + cnt[ADDR_W-1:0];
        wdata_q <= bus.s_data;
        cnt     <= cnt_inc;
`ifdef BOOT_CHECKSUM_EN
        sum <= sum + bus.s_data;
        if (last_word) chk_phase <= 1'b1;
`endif
      end
      // Pointer moves on the same edge as the channel's final word, so there is no bubble.
      if (advance) begin
        cnt <= '0;
        if (nxt_found) ch <= nxt_ch;
`ifdef BOOT_CHECKSUM_EN
        chk_phase <= 1'b0;
        sum       <= '0;
`endif
      end
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign fsm_state     = state;
endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: vector table of loads, write scoreboard, corner sequences.
module tb_mem_boot_loader;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int NCH      = 2;
  localparam int RST_HOLD = 2;
  localparam int BW       = NCH * ADDR_W;
  localparam int LW       = NCH * (ADDR_W + 1);
  localparam int W        = NCH + ADDR_W + DATA_W;

  typedef struct {
    logic [ADDR_W-1:0] base0;
    logic [ADDR_W-1:0] base1;
    logic [ADDR_W:0]   len0;
    logic [ADDR_W:0]   len1;
    bit                toggle;
    bit                poke;
    int                exp_writes;
    logic [ADDR_W-1:0] exp_last_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] fsm_state;

  int n_vec = 0;
  int n_fail = 0;
  int n_writes = 0;
  int cyc_now = 0;
  int last_acc_cyc = 0;
  int load_no = 1;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] stream[$];
  vec_t              vecs[6];

  mem_boot_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH)) bus ();

  mem_boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fsm_state(fsm_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write on the memory port must match the head of exp_q.
  always @(negedge clk) begin
    if (bus.mem_we != '0) begin
      n_writes++;
      last_addr = bus.mem_addr;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_write: got we=%b addr=%0d data=0x%0h, expected no write",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end else begin
        check("mem_write", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_cpu_rst",   64'(bus.cpu_rst),   64'(1));
    check("rst_s_ready",   64'(bus.s_ready),   64'(0));
    check("rst_mem_we",    64'(bus.mem_we),    64'(0));
    check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_done",      64'(bus.done),      64'(0));
    check("rst_err",       64'(bus.err),       64'(0));
  endtask

  // Driver tasks
  task automatic do_start(input logic [ADDR_W-1:0] b0, input logic [ADDR_W-1:0] b1,
                          input logic [ADDR_W:0] l0, input logic [ADDR_W:0] l1);
    bus.ch_base = {b1, b0};
    bus.ch_len  = {l1, l0};
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.ch_base = BW'($urandom);
    bus.ch_len  = LW'($urandom);
    check("start_cpu_rst", 64'(bus.cpu_rst), 64'(1));
    check("start_busy",    64'(bus.busy),    64'(1));
    check("start_done",    64'(bus.done),    64'(0));
  endtask

  task automatic feed(input bit toggle, input bit poke);
    int cyc = 0;
    int idx = 0;
    int n = stream.size();
    while (idx < n && cyc < 200) begin
      bus.s_valid = (toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      bus.s_data  = stream[idx];
      bus.start   = poke && (idx == 1);
      if (bus.s_valid && bus.s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.s_valid  = 1'b0;
    bus.start    = 1'b0;
    last_acc_cyc = cyc_now;
    check("stream_accepted", 64'(idx), 64'(n));
  endtask

  // Stray s_valid while the loader is not in LOAD must not write anything.
  task automatic wait_release(input int ref_c);
    int guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    while (bus.cpu_rst && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    bus.s_valid = 1'b0;
    check("release_delay", 64'(cyc_now - 2 - ref_c), 64'(RST_HOLD));
    check("run_cpu_rst",   64'(bus.cpu_rst), 64'(0));
    check("run_done",      64'(bus.done),    64'(1));
    check("run_busy",      64'(bus.busy),    64'(0));
    check("run_err",       64'(bus.err),     64'(0));
  endtask

  task automatic run_load(input vec_t v);
    int wr0 = n_writes;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W:0]   l;
    logic [DATA_W-1:0] w, sum;
    logic [NCH-1:0]    we1;
    stream.delete();
    for (int c = 0; c < NCH; c++) begin
      b   = (c == 0) ? v.base0 : v.base1;
      l   = (c == 0) ? v.len0 : v.len1;
      we1 = NCH'(1) << c;
      sum = '0;
      for (int i = 0; i < int'(l); i++) begin
        w = (DATA_W'(load_no) << 24) | (DATA_W'(c) << 16) | DATA_W'(i);
        stream.push_back(w);
        sum = sum + w;
        exp_q.push_back({we1, ADDR_W'(int'(b) + i), w});
      end
`ifdef BOOT_CHECKSUM_EN
      if (l != '0) stream.push_back(sum);
`endif
    end
    load_no++;
    do_start(v.base0, v.base1, v.len0, v.len1);
    feed(v.toggle, v.poke);
    wait_release(last_acc_cyc);
    check("write_count",   64'(n_writes - wr0), 64'(v.exp_writes));
    check("exp_q_drained", 64'(exp_q.size()),   64'(0));
    if (v.exp_writes > 0) check("last_addr", 64'(last_addr), 64'(v.exp_last_addr));
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    // base0, base1, len0, len1, toggle, poke, writes, last address
    vecs[0] = '{9'd0,   9'd250, 10'd3, 10'd2, 1'b0, 1'b0, 5, 9'd251};
    vecs[1] = '{9'd0,   9'd250, 10'd3, 10'd2, 1'b1, 1'b1, 5, 9'd251};
    vecs[2] = '{9'd7,   9'd100, 10'd0, 10'd4, 1'b0, 1'b0, 4, 9'd103};
    vecs[3] = '{9'd0,   9'd0,   10'd0, 10'd0, 1'b0, 1'b0, 0, 9'd0};
    vecs[4] = '{9'd510, 9'd0,   10'd4, 10'd0, 1'b0, 1'b1, 4, 9'd1};
    vecs[5] = '{9'd0,   9'd300, 10'd1, 10'd1, 1'b1, 1'b0, 2, 9'd300};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.ch_base = '0;
    bus.ch_len  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_load(vecs[v]);

    // Reset after two of five words: abort, then a fresh load from IDLE.
    exp_q.push_back({2'b01, 9'd0, 32'h0000_00A0});
    exp_q.push_back({2'b01, 9'd1, 32'h0000_00A1});
    do_start(9'd0, 9'd250, 10'd3, 10'd2);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_00A0;
    @(negedge clk);
    bus.s_data  = 32'h0000_00A1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    check("abort_exp_q", 64'(exp_q.size()), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    run_load(vecs[0]);

`ifdef BOOT_CHECKSUM_EN
    stream.delete();
    stream.push_back(32'd5);
    stream.push_back(32'd7);
    stream.push_back(32'd12);
    exp_q.push_back({2'b01, 9'd0, 32'd5});
    exp_q.push_back({2'b01, 9'd1, 32'd7});
    do_start(9'd0, 9'd0, 10'd2, 10'd0);
    feed(1'b0, 1'b0);
    wait_release(last_acc_cyc);

    stream.delete();
    stream.push_back(32'd5);
    stream.push_back(32'd7);
    stream.push_back(32'd13);
    exp_q.push_back({2'b01, 9'd0, 32'd5});
    exp_q.push_back({2'b01, 9'd1, 32'd7});
    do_start(9'd0, 9'd0, 10'd2, 10'd0);
    feed(1'b0, 1'b0);
    bus.s_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.s_valid = 1'b0;
    check("cs_err",     64'(bus.err),     64'(1));
    check("cs_cpu_rst", 64'(bus.cpu_rst), 64'(1));
    check("cs_done",    64'(bus.done),    64'(0));
    check("cs_busy",    64'(bus.busy),    64'(0));
    check("cs_s_ready", 64'(bus.s_ready), 64'(0));

    stream.delete();
    do_start(9'd0, 9'd0, 10'd0, 10'd0);
    check("cs_err_cleared", 64'(bus.err), 64'(0));
    feed(1'b0, 1'b0);
    wait_release(last_acc_cyc);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
